// File: rtl/cordic_iter_ctrl.sv
// ============================================================================
// Module   : cordic_iter_ctrl
// Brief    : Iterative sequencer driving one combinational CORDIC core for
//            p_ITERS micro-rotations per job, with valid/ready job in/out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_iter_ctrl #(
  parameter  int p_WIDTH      = 32,
  parameter  int p_ITERS      = 24,
  localparam int p_LOG2_WIDTH = $clog2(p_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  // job request side
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [p_WIDTH-1:0]      i_in_x,
  input  logic [p_WIDTH-1:0]      i_in_y,
  input  logic [p_WIDTH-1:0]      i_in_z,
  input  logic                    i_in_mode,
  // result side
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [p_WIDTH-1:0]      o_out_x,
  output logic [p_WIDTH-1:0]      o_out_y,
  output logic [p_WIDTH-1:0]      o_out_z,
  output logic                    o_busy,
  // core side
  output logic [p_WIDTH-1:0]      o_xprev,
  output logic [p_WIDTH-1:0]      o_yprev,
  output logic [p_WIDTH-1:0]      o_zprev,
  output logic                    o_dir,
  output logic                    o_mode,
  output logic [p_WIDTH-1:0]      o_angle,
  output logic [p_LOG2_WIDTH-1:0] o_shift_amnt,
  input  logic [p_WIDTH-1:0]      i_xnext,
  input  logic [p_WIDTH-1:0]      i_ynext,
  input  logic [p_WIDTH-1:0]      i_znext
);

  localparam real                   c_PI   = 3.14159265358979323846;
  localparam logic [p_LOG2_WIDTH-1:0] c_LAST = p_LOG2_WIDTH'(p_ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // atan(2^-i) scaled so that a full circle spans 2^p_WIDTH, rounded to nearest
  function automatic logic [p_WIDTH-1:0] f_atan_lut(input int i);
    real r;
    r = $atan(2.0 ** (-i)) * (2.0 ** (p_WIDTH - 1)) / c_PI;
    return p_WIDTH'(longint'(r));
  endfunction

  logic [p_WIDTH-1:0] w_lut [p_WIDTH];

  for (genvar g = 0; g < p_WIDTH; g++) begin : g_lut
    localparam logic [p_WIDTH-1:0] c_ENTRY = f_atan_lut(g);
    assign w_lut[g] = c_ENTRY;
  end

  state_t                  r_state;
  logic [p_LOG2_WIDTH-1:0] r_count;
  logic [p_WIDTH-1:0]      r_x;
  logic [p_WIDTH-1:0]      r_y;
  logic [p_WIDTH-1:0]      r_z;
  logic                    r_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_mode  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_x     <= i_in_x;
            r_y     <= i_in_y;
            r_z     <= i_in_z;
            r_mode  <= i_in_mode;
            r_count <= '0;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          r_x <= i_xnext;
          r_y <= i_ynext;
          r_z <= i_znext;
          // count freezes on the last iteration so the core view stays put in DONE
          if (r_count == c_LAST) begin
            r_state <= S_DONE;
          end else begin
            r_count <= r_count + p_LOG2_WIDTH'(1);
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_DONE);
  assign o_busy      = (r_state == S_ITER) || (r_state == S_DONE);
  assign o_out_x     = r_x;
  assign o_out_y     = r_y;
  assign o_out_z     = r_z;

  // Vectoring drives y towards zero, rotation drives z towards zero
  assign o_dir        = r_mode ? r_y[p_WIDTH-1] : ~r_z[p_WIDTH-1];
  assign o_mode       = r_mode;
  assign o_xprev      = r_x;
  assign o_yprev      = r_y;
  assign o_zprev      = r_z;
  assign o_shift_amnt = r_count;
  assign o_angle      = w_lut[r_count];

endmodule

`default_nettype wire

// File: tb/tb_cordic_iter_ctrl.sv
// ============================================================================
// Module   : tb_cordic_iter_ctrl
// Brief    : Directed bench for cordic_iter_ctrl with a behavioural core model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_iter_ctrl;

  localparam int  c_W  = 32;
  localparam int  c_N  = 24;
  localparam real c_PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main DUT (24 iterations)
  logic            in_valid, in_ready, in_mode, out_valid, out_ready, busy;
  logic [c_W-1:0]  in_x, in_y, in_z, out_x, out_y, out_z;
  logic [c_W-1:0]  xprev, yprev, zprev, angle, xnext, ynext, znext;
  logic            dir, mode;
  logic [4:0]      shift_amnt;

  // single-iteration DUT
  logic            in_valid1, in_ready1, out_valid1, out_ready1, busy1, dir1, mode1;
  logic [c_W-1:0]  out_x1, out_y1, out_z1;
  logic [c_W-1:0]  xprev1, yprev1, zprev1, angle1, xnext1, ynext1, znext1;
  logic [4:0]      shift1;

  cordic_iter_ctrl #(.p_WIDTH(c_W), .p_ITERS(c_N)) dut (
    .clk(clk), .rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_x(in_x), .i_in_y(in_y), .i_in_z(in_z), .i_in_mode(in_mode),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_x(out_x), .o_out_y(out_y), .o_out_z(out_z), .o_busy(busy),
    .o_xprev(xprev), .o_yprev(yprev), .o_zprev(zprev),
    .o_dir(dir), .o_mode(mode), .o_angle(angle), .o_shift_amnt(shift_amnt),
    .i_xnext(xnext), .i_ynext(ynext), .i_znext(znext)
  );

  cordic_iter_ctrl #(.p_WIDTH(c_W), .p_ITERS(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_in_valid(in_valid1), .o_in_ready(in_ready1),
    .i_in_x(in_x), .i_in_y(in_y), .i_in_z(in_z), .i_in_mode(in_mode),
    .o_out_valid(out_valid1), .i_out_ready(out_ready1),
    .o_out_x(out_x1), .o_out_y(out_y1), .o_out_z(out_z1), .o_busy(busy1),
    .o_xprev(xprev1), .o_yprev(yprev1), .o_zprev(zprev1),
    .o_dir(dir1), .o_mode(mode1), .o_angle(angle1), .o_shift_amnt(shift1),
    .i_xnext(xnext1), .i_ynext(ynext1), .i_znext(znext1)
  );

  // one micro-rotation; d=1 rotates counter-clockwise and subtracts the angle
  function automatic logic [3*c_W-1:0] f_step(input logic [c_W-1:0] x, y, z,
                                               input logic d, input logic [4:0] s,
                                               input logic [c_W-1:0] a);
    logic [c_W-1:0] xs, ys;
    xs = $signed(x) >>> s;
    ys = $signed(y) >>> s;
    if (d) return {x - ys, y + xs, z - a};
    else   return {x + ys, y - xs, z + a};
  endfunction

  always_comb {xnext, ynext, znext}    = f_step(xprev, yprev, zprev, dir, shift_amnt, angle);
  always_comb {xnext1, ynext1, znext1} = f_step(xprev1, yprev1, zprev1, dir1, shift1, angle1);

  int             n_tests = 0;
  int             n_fail  = 0;
  logic [c_W-1:0] lut [c_N];
  logic [c_W-1:0] mx, my, mz, ix, iy, iz;
  logic           mm, md;

  task automatic t_check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // present a job at the current negedge and let it be accepted
  task automatic t_accept(input logic [c_W-1:0] x, y, z, input logic m);
    in_x = x; in_y = y; in_z = z; in_mode = m; in_valid = 1'b1;
    t_check("acc_rdy", in_ready, 1);
    mx = x; my = y; mz = z; mm = m; ix = x; iy = y; iz = z;
    @(negedge clk);
    t_check("acc_busy", busy, 1);
    t_check("acc_nrdy", in_ready, 0);
  endtask

  // probe each iteration, then compare the result against the reference
  task automatic t_iterate(input string tag);
    int   cyc;
    real  k, phi, xid, yid, dx, dy;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      md = mm ? my[c_W-1] : ~mz[c_W-1];
      t_check({tag, "_shift"}, shift_amnt, cyc);
      t_check({tag, "_angle"}, angle, lut[cyc % c_N]);
      t_check({tag, "_dir"}, dir, md);
      if (cyc == 1) t_check({tag, "_lut1"}, angle, 32'h12E4_051E);
      {mx, my, mz} = f_step(mx, my, mz, md, 5'(cyc), lut[cyc % c_N]);
      @(negedge clk);
      cyc++;
    end
    t_check({tag, "_latency"}, cyc, c_N);
    t_check({tag, "_x"}, out_x, mx);
    t_check({tag, "_y"}, out_y, my);
    t_check({tag, "_z"}, out_z, mz);
    // gain-scaled ideal rotation by the angle the z accumulator actually consumed
    k = 1.0;
    for (int i = 0; i < c_N; i++) k = k * $sqrt(1.0 + 2.0 ** (-2 * i));
    phi = $itor($signed(iz - out_z)) * c_PI / (2.0 ** (c_W - 1));
    xid = k * ($itor($signed(ix)) * $cos(phi) - $itor($signed(iy)) * $sin(phi));
    yid = k * ($itor($signed(iy)) * $cos(phi) + $itor($signed(ix)) * $sin(phi));
    dx  = $itor($signed(out_x)) - xid;
    dy  = $itor($signed(out_y)) - yid;
    t_check({tag, "_x_tol"}, (dx <= 64.0 && dx >= -64.0), 1);
    t_check({tag, "_y_tol"}, (dy <= 64.0 && dy >= -64.0), 1);
  endtask

  task automatic t_release();
    out_ready = 1'b1;
    @(negedge clk);
    t_check("rel_rdy", in_ready, 1);
    t_check("rel_nvalid", out_valid, 0);
    t_check("rel_nbusy", busy, 0);
    out_ready = 1'b0;
  endtask

  function automatic logic f_near(input logic [c_W-1:0] v, input logic [c_W-1:0] ref_v,
                                  input int tol);
    int d;
    d = $signed(v - ref_v);
    return (d <= tol) && (d >= -tol);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    for (int i = 0; i < c_N; i++)
      lut[i] = 32'($rtoi($atan(2.0 ** (-i)) * (2.0 ** (c_W - 1)) / c_PI + 0.5));

    rst = 1'b1; in_valid = 0; in_valid1 = 0; out_ready = 0; out_ready1 = 0;
    in_x = '0; in_y = '0; in_z = '0; in_mode = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    t_check("rst_rdy", in_ready, 1);
    t_check("rst_valid", out_valid, 0);
    t_check("rst_busy", busy, 0);
    t_check("rst_angle", angle, 32'h2000_0000);
    t_check("rst_shift", shift_amnt, 0);
    t_check("rst_xprev", xprev, 0);
    t_check("rst_rdy1", in_ready1, 1);

    // rotation by +45 degrees of (1,0)
    t_accept(32'h4000_0000, 32'h0, 32'h2000_0000, 1'b0);
    in_valid = 1'b0;
    t_iterate("rot");
    t_check("rot_zres", f_near(out_z, 32'h0, 256), 1);
    t_release();

    // vectoring of (0.5,0.5)
    t_accept(32'h2000_0000, 32'h2000_0000, 32'h0, 1'b1);
    in_valid = 1'b0;
    t_iterate("vec");
    t_check("vec_zres", f_near(out_z, 32'h2000_0000, 256), 1);
    t_release();

    // backpressure: result held while new requests are ignored
    t_accept(32'h3000_0000, 32'h1000_0000, 32'hF000_0000, 1'b0);
    in_valid = 1'b0;
    t_iterate("bp");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_x = $urandom; in_y = $urandom; in_z = $urandom; in_mode = 1'($urandom);
      @(negedge clk);
      t_check("bp_hold_x", out_x, mx);
      t_check("bp_hold_z", out_z, mz);
      t_check("bp_valid", out_valid, 1);
      t_check("bp_nrdy", in_ready, 0);
    end
    in_valid = 1'b0;
    t_release();

    // reset at iteration 7 discards the job
    t_accept(32'h4000_0000, 32'h0, 32'hE000_0000, 1'b0);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    t_check("mid_shift", shift_amnt, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    t_check("mid_rdy", in_ready, 1);
    t_check("mid_valid", out_valid, 0);
    t_check("mid_busy", busy, 0);
    t_check("mid_xprev", xprev, 0);
    t_check("mid_shift0", shift_amnt, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    t_check("mid_noout", seen, 0);
    t_accept(32'h3000_0000, 32'hE000_0000, 32'h0, 1'b1);
    in_valid = 1'b0;
    t_iterate("post");
    t_release();

    // back-to-back with in_valid held high throughout
    out_ready = 1'b1;
    t_accept(32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 1'b0);
    in_x = 32'h1800_0000; in_y = 32'h0800_0000; in_z = 32'h0; in_mode = 1'b1;
    t_iterate("b2bA");
    @(negedge clk);
    t_check("b2b_rdy", in_ready, 1);
    t_check("b2b_nvalid", out_valid, 0);
    t_accept(32'h1800_0000, 32'h0800_0000, 32'h0, 1'b1);
    in_valid = 1'b0;
    t_iterate("b2bB");
    t_release();

    // single-iteration build: result one cycle after accept
    in_x = 32'h4000_0000; in_y = 32'h0; in_z = 32'h2000_0000; in_mode = 1'b0;
    in_valid1 = 1'b1;
    t_check("one_rdy", in_ready1, 1);
    @(negedge clk);
    in_valid1 = 1'b0;
    t_check("one_nvalid", out_valid1, 0);
    t_check("one_dir", dir1, 1);
    t_check("one_angle", angle1, 32'h2000_0000);
    @(negedge clk);
    t_check("one_valid", out_valid1, 1);
    t_check("one_x", out_x1, 32'h4000_0000);
    t_check("one_y", out_y1, 32'h4000_0000);
    t_check("one_z", out_z1, 32'h0);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    t_check("one_idle", in_ready1, 1);
    t_check("one_done", out_valid1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
